// File: rtl/ysyx_25040129_axi_sram_resp.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_25040129_axi_sram_resp
// Description : AXI4 responder backed by an on-chip 32-bit word SRAM.
//               The read path accepts an AR request, waits RD_LATENCY cycles,
//               then streams FIXED or INCR burst beats. WRAP bursts are
//               treated as INCR. The write path collects AW and W in either
//               order, commits under the byte strobes and returns one B
//               response. Only one transaction is in flight at a time.
// Options     : define SRAM_RESP_BOUND_CHECK_EN to answer addresses at or
//               above MEM_WORDS*4 with SLVERR, with zero read data and the
//               write dropped. Without it, every address aliases modulo the
//               SRAM size.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25040129_axi_sram_resp #(
    parameter int MEM_WORDS  = 1024,
    parameter int RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    input  logic [2:0]  arsize,
    input  logic [7:0]  arlen,
    input  logic [1:0]  arburst,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,
    output logic        rlast,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int         IDX_W    = $clog2(MEM_WORDS);
    localparam int         ADDR_W   = IDX_W + 2;
    localparam logic [3:0] LAT_LAST = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        RD_WAIT    = 3'd1,
        RD_BEAT    = 3'd2,
        WR_COLLECT = 3'd3,
        WR_RESP    = 3'd4
    } state_e;

    state_e      state_q, state_d;

    logic [31:0] raddr_q, raddr_d;
    logic [7:0]  rlen_q, rlen_d;
    logic [7:0]  beat_q, beat_d;
    logic [1:0]  rsize_q, rsize_d;
    logic        rincr_q, rincr_d;
    logic [3:0]  lat_q, lat_d;

    logic        aw_got_q, aw_got_d;
    logic        w_got_q, w_got_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  bresp_q, bresp_d;

    logic [31:0] mem_q [MEM_WORDS];

    logic              w_commit;
    logic              w_rd_oob;
    logic [ADDR_W-1:0] w_rinc;
    logic [31:0]       w_raddr_nxt;
    logic [IDX_W-1:0]  w_ridx;
    logic [IDX_W-1:0]  w_widx;

    // Beat address steps by the beat size and wraps inside the SRAM window;
    // bits above the window are carried along untouched.
    assign w_rinc      = {{(ADDR_W-1){1'b0}}, 1'b1} << rsize_q;
    assign w_raddr_nxt = {raddr_q[31:ADDR_W], raddr_q[ADDR_W-1:0] + w_rinc};
    assign w_ridx      = raddr_q[ADDR_W-1:2];
    assign w_widx      = waddr_d[ADDR_W-1:2];

`ifdef SRAM_RESP_BOUND_CHECK_EN
    assign w_rd_oob = |raddr_q[31:ADDR_W];
`else
    assign w_rd_oob = 1'b0;
`endif

    // Handshake readies come from the current state. They are held low while reset is asserted.
    assign arready = rst && (state_q == IDLE) && !(awvalid || wvalid);
    assign awready = rst && ((state_q == IDLE) || ((state_q == WR_COLLECT) && !aw_got_q));
    assign wready  = rst && ((state_q == IDLE) || ((state_q == WR_COLLECT) && !w_got_q));

    assign rvalid  = (state_q == RD_BEAT);
    assign rlast   = rvalid && (beat_q == rlen_q);
    assign rdata   = (rvalid && !w_rd_oob) ? mem_q[w_ridx] : 32'd0;
    assign rresp   = (rvalid && w_rd_oob) ? 2'b10 : 2'b00;
    assign bvalid  = (state_q == WR_RESP);
    assign bresp   = bvalid ? bresp_q : 2'b00;

    // Next-state and capture logic for both the read and the write channels.
    always_comb begin
        state_d  = state_q;
        raddr_d  = raddr_q;
        rlen_d   = rlen_q;
        beat_d   = beat_q;
        rsize_d  = rsize_q;
        rincr_d  = rincr_q;
        lat_d    = lat_q;
        aw_got_d = aw_got_q;
        w_got_d  = w_got_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        bresp_d  = bresp_q;
        w_commit = 1'b0;

        case (state_q)
            IDLE: begin
                if (awvalid || wvalid) begin
                    if (awvalid) begin
                        aw_got_d = 1'b1;
                        waddr_d  = awaddr;
                    end
                    if (wvalid) begin
                        w_got_d = 1'b1;
                        wdata_d = wdata;
                        wstrb_d = wstrb;
                    end
                    if (awvalid && wvalid) begin
                        w_commit = 1'b1;
                        state_d  = WR_RESP;
                    end else begin
                        state_d = WR_COLLECT;
                    end
                end else if (arvalid) begin
                    raddr_d = araddr;
                    rlen_d  = arlen;
                    rsize_d = arsize[1:0];
                    rincr_d = |arburst;
                    beat_d  = 8'd0;
                    lat_d   = 4'd0;
                    state_d = (RD_LATENCY == 0) ? RD_BEAT : RD_WAIT;
                end
            end
            WR_COLLECT: begin
                if (!aw_got_q && awvalid) begin
                    aw_got_d = 1'b1;
                    waddr_d  = awaddr;
                    w_commit = 1'b1;
                    state_d  = WR_RESP;
                end
                if (!w_got_q && wvalid) begin
                    w_got_d  = 1'b1;
                    wdata_d  = wdata;
                    wstrb_d  = wstrb;
                    w_commit = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bready) begin
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                    state_d  = IDLE;
                end
            end
            RD_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    state_d = RD_BEAT;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            RD_BEAT: begin
                if (rready) begin
                    if (beat_q == rlen_q) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 8'd1;
                        if (rincr_q) begin
                            raddr_d = w_raddr_nxt;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SRAM_RESP_BOUND_CHECK_EN
        if (w_commit) begin
            bresp_d = (|waddr_d[31:ADDR_W]) ? 2'b10 : 2'b00;
        end
`else
        if (w_commit) begin
            bresp_d = 2'b00;
        end
`endif
    end

    // Control and capture registers. Reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            raddr_q  <= 32'd0;
            rlen_q   <= 8'd0;
            beat_q   <= 8'd0;
            rsize_q  <= 2'd0;
            rincr_q  <= 1'b0;
            lat_q    <= 4'd0;
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            waddr_q  <= 32'd0;
            wdata_q  <= 32'd0;
            wstrb_q  <= 4'd0;
            bresp_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            raddr_q  <= raddr_d;
            rlen_q   <= rlen_d;
            beat_q   <= beat_d;
            rsize_q  <= rsize_d;
            rincr_q  <= rincr_d;
            lat_q    <= lat_d;
            aw_got_q <= aw_got_d;
            w_got_q  <= w_got_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            bresp_q  <= bresp_d;
        end
    end

    // SRAM byte-lane write on the edge that enters WR_RESP. The contents survive reset.
    always_ff @(posedge clk) begin
        if (rst && w_commit && !bresp_d[1]) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_d[i]) begin
                    mem_q[w_widx][8*i +: 8] <= wdata_d[8*i +: 8];
                end
            end
        end
    end

    // Address bits that never select a word, and the unsupported arsize MSB.
    logic w_unused;
    assign w_unused = &{1'b0, arsize[2], waddr_d[1:0], waddr_d[31:ADDR_W]};

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040129_axi_sram_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_25040129_axi_sram_resp
// Description : Randomised self-checking bench for the AXI SRAM responder.
//               A word-array memory model and a queue of expected read beats
//               form the reference. One process checks every valid read beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040129_axi_sram_resp;

    localparam int MEM_WORDS  = 1024;
    localparam int RD_LATENCY = 2;
    localparam int SPAN       = MEM_WORDS * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [2:0]  arsize;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        rlast;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    ysyx_25040129_axi_sram_resp #(
        .MEM_WORDS (MEM_WORDS),
        .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .araddr (araddr),
        .arvalid(arvalid),
        .arready(arready),
        .arsize (arsize),
        .arlen  (arlen),
        .arburst(arburst),
        .rdata  (rdata),
        .rresp  (rresp),
        .rvalid (rvalid),
        .rready (rready),
        .rlast  (rlast),
        .awaddr (awaddr),
        .awvalid(awvalid),
        .awready(awready),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .wvalid (wvalid),
        .wready (wready),
        .bresp  (bresp),
        .bvalid (bvalid),
        .bready (bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic [31:0] model [MEM_WORDS];
    beat_t       exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Every cycle with a valid read beat: compare against the head of the expected queue.
    always @(negedge clk) begin
        if (rst && rvalid) begin
            if (exp_q.size() == 0) begin
                chk("r_unexpected", {31'd0, rvalid}, 32'd0);
            end else begin
                chk("rdata", rdata, exp_q[0].data);
                chk("rlast", {31'd0, rlast}, {31'd0, exp_q[0].last});
                chk("rresp", {30'd0, rresp}, 32'd0);
                if (rready) void'(exp_q.pop_front());
            end
        end
    end

    // Expected beats follow from the burst rules applied to the model memory.
    task automatic push_exp(input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] sz, input logic [1:0] br);
        logic [31:0] ba;
        beat_t       b;
        ba = a;
        for (int k = 0; k <= int'(len); k++) begin
            b.data = model[(ba >> 2) % MEM_WORDS];
            b.last = (k == int'(len));
            exp_q.push_back(b);
            if (br != 2'b00) ba = (ba + (32'd1 << sz)) % SPAN;
        end
    endtask

    // lead > 0: W is presented lead cycles before AW; lead < 0: AW leads.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int lead, input bit ar_low);
        int aw_st = (lead > 0) ? lead : 0;
        int w_st  = (lead < 0) ? -lead : 0;
        int t = 0;
        int hold;
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        while (!(aw_done && w_done) && t < 60) begin
            awvalid = !aw_done && (t >= aw_st);
            awaddr  = a;
            wvalid  = !w_done && (t >= w_st);
            wdata   = d;
            wstrb   = s;
            @(negedge clk);
            if (ar_low) chk("arready_low_wr", {31'd0, arready}, 32'd0);
            if (w_done && !aw_done) chk("wready_low", {31'd0, wready}, 32'd0);
            if (aw_done && !w_done) chk("awready_low", {31'd0, awready}, 32'd0);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            @(posedge clk); #1;
            aw_done = aw_done | hs_aw;
            w_done  = w_done | hs_w;
            t++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            chk("wr_timeout", {31'd0, aw_done & w_done}, 32'd1);
        end else begin
            for (int i = 0; i < 4; i++)
                if (s[i]) model[(a >> 2) % MEM_WORDS][8*i +: 8] = d[8*i +: 8];
            hold = $urandom_range(0, 3);
            for (int k = 0; k <= hold; k++) begin
                bready = (k == hold);
                @(negedge clk);
                chk("bvalid", {31'd0, bvalid}, 32'd1);
                chk("bresp", {30'd0, bresp}, 32'd0);
                if (ar_low) chk("arready_low_b", {31'd0, arready}, 32'd0);
                @(posedge clk); #1;
            end
            bready = 1'b0;
            chk("bvalid_drop", {31'd0, bvalid}, 32'd0);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] br, input int stall_at, input int stall_len,
                           input bit use_lit, input logic [31:0] lit0);
        int T = -1;
        int guard = 0;
        int done = 0;
        int st = 0;
        bit prev_cont = 0, first = 1;
        push_exp(a, len, sz, br);
        arvalid = 1'b1; araddr = a; arlen = len; arsize = sz; arburst = br; rready = 1'b0;
        while (T < 0 && guard < 60) begin
            @(negedge clk);
            if (arvalid && arready) T = cyc;
            @(posedge clk); #1;
            guard++;
        end
        arvalid = 1'b0;
        if (T < 0) begin
            chk("ar_timeout", 32'(T < 0), 32'd0);
            exp_q.delete();
            return;
        end
        guard = 0;
        while (done <= int'(len) && guard < 300) begin
            if (stall_at == done && st < stall_len) begin
                rready = 1'b0;
                st++;
            end else begin
                rready = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            if (prev_cont) chk("no_bubble", {31'd0, rvalid}, 32'd1);
            if (rvalid && first) begin
                chk("first_lat", cyc, T + 1 + RD_LATENCY);
                if (use_lit) chk("lit_word", rdata, lit0);
                first = 0;
            end
            prev_cont = rvalid && rready && !rlast;
            if (rvalid && rready) done++;
            @(posedge clk); #1;
            guard++;
        end
        rready = 1'b0;
        if (done <= int'(len)) begin
            chk("r_timeout", done, int'(len) + 1);
            exp_q.delete();
        end else begin
            chk("rvalid_drop", {31'd0, rvalid}, 32'd0);
            chk("rlast_drop", {31'd0, rlast}, 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hi;
        rst = 1'b0;
        araddr = '0; arvalid = 0; arsize = '0; arlen = '0; arburst = '0; rready = 0;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rlast", {31'd0, rlast}, 32'd0);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_resp", {28'd0, rresp, bresp}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("idle_arready", {31'd0, arready}, 32'd1);
        chk("idle_awready", {31'd0, awready}, 32'd1);
        chk("idle_wready", {31'd0, wready}, 32'd1);
        @(posedge clk); #1;

        // Give a known value to every word the bench reads back.
        for (int i = 0; i < 48; i++) do_write(i * 4, $urandom(), 4'hF, 0, 0);
        do_write(SPAN - 8, $urandom(), 4'hF, 0, 0);
        do_write(SPAN - 4, $urandom(), 4'hF, 0, 0);

        // Directed cases with literal expectations.
        do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
        do_read(32'h10, 8'd0, 3'd2, 2'b01, -1, 0, 1, 32'hDEADBEEF);
        do_write(32'h14, 32'h11223344, 4'hF, 3, 0);
        do_read(32'h14, 8'd0, 3'd2, 2'b01, -1, 0, 1, 32'h11223344);
        do_write(32'h14, 32'h0000AB00, 4'h2, 0, 0);
        do_read(32'h14, 8'd0, 3'd2, 2'b01, -1, 0, 1, 32'h1122AB44);
        do_read(32'h10, 8'd3, 3'd2, 2'b01, -1, 0, 1, 32'hDEADBEEF);
        do_read(32'h10, 8'd3, 3'd2, 2'b01, 1, 5, 0, 32'd0);
        do_read(32'h14, 8'd2, 3'd2, 2'b00, -1, 0, 1, 32'h1122AB44);
        do_write(32'h14, 32'hFFFFFFFF, 4'h0, -2, 0);
        do_read(32'h14, 8'd0, 3'd2, 2'b01, -1, 0, 1, 32'h1122AB44);
        do_read(SPAN - 8, 8'd3, 3'd2, 2'b01, -1, 0, 0, 32'd0);
        do_read(32'h22, 8'd5, 3'd0, 2'b10, 2, 2, 0, 32'd0);

        // Read request arriving together with a full write: the write goes first.
        arvalid = 1'b1; araddr = 32'h30; arlen = 8'd1; arsize = 3'd2; arburst = 2'b01;
        do_write(32'h30, 32'hCAFEF00D, 4'hF, 0, 1);
        do_read(32'h30, 8'd1, 3'd2, 2'b01, -1, 0, 1, 32'hCAFEF00D);

        // Reset in the middle of a burst.
        push_exp(32'h40, 8'd7, 3'd2, 2'b01);
        arvalid = 1'b1; araddr = 32'h40; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
        @(posedge clk); #1;
        arvalid = 1'b0;
        rready  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("midrst_rlast", {31'd0, rlast}, 32'd0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_arready", {31'd0, arready}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1; rready = 1'b0;
        do_read(32'h40, 8'd3, 3'd2, 2'b01, -1, 0, 0, 32'd0);

        // Randomised traffic; upper address bits are junk and alias away.
        for (int it = 0; it < 60; it++) begin
            hi = $urandom() & 32'hFFFF_F000;
            if ($urandom_range(0, 1) == 1)
                do_write(hi | ($urandom_range(0, 47) * 4), $urandom(), 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 6)) - 3, 0);
            else
                do_read(hi | $urandom_range(0, 127), 8'($urandom_range(0, 7)),
                        3'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, 32'd0);
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
